// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for the shared memory; ready pulses MEM_LAT+1 cycles after grant, losers wait with req held.
// Fixed-latency access, CPU-first with DMA starvation limit; MEM_PORT_ARBITER_LOCK_EN adds dma_lock bus locking.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wd,
`ifdef MEM_PORT_ARBITER_LOCK_EN
    input  logic        dma_lock,
`endif
    output logic [31:0] dma_rd,
    output logic        dma_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        owner,
    output logic        busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [3:0]    WAIT_INIT  = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wd_q, wd_d;
    logic [31:0]   cpu_rd_q, cpu_rd_d;
    logic [31:0]   dma_rd_q, dma_rd_d;
    logic          grant_cpu, grant_dma, locked_go;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic          lock_q, lock_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            starve_q <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            cpu_rd_q <= cpu_rd_d;
            dma_rd_q <= dma_rd_d;
`ifdef MEM_PORT_ARBITER_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        starve_d  = starve_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        cpu_rd_d  = cpu_rd_q;
        dma_rd_d  = dma_rd_q;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        locked_go = 1'b0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        lock_d    = lock_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_PORT_ARBITER_LOCK_EN
                locked_go = lock_q && dma_req && dma_lock;
`endif
                if (locked_go)
                    grant_dma = 1'b1;
                else if (dma_req && (!cpu_req || starve_q == STARVE_LIM))
                    grant_dma = 1'b1;
                else if (cpu_req)
                    grant_cpu = 1'b1;

                if (grant_dma) begin
                    owner_d = 1'b1;
                    we_d    = dma_we;
                    addr_d  = dma_addr;
                    wd_d    = dma_wd;
                    // Starvation count stays frozen across a locked burst
                    if (!locked_go)
                        starve_d = '0;
                end else if (grant_cpu) begin
                    owner_d = 1'b0;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wd_d    = cpu_wd;
                    if (!dma_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + 1'b1;
                end

                if (grant_dma || grant_cpu) begin
                    wait_d  = WAIT_INIT;
                    state_d = ACCESS;
                end
`ifdef MEM_PORT_ARBITER_LOCK_EN
                lock_d = grant_dma && dma_lock;
`endif
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q)
                            dma_rd_d = mem_rd;
                        else
                            cpu_rd_d = mem_rd;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wd    = wd_q;
    assign cpu_ready = (state_q == RESP) && !owner_q;
    assign dma_ready = (state_q == RESP) && owner_q;
    assign cpu_rd    = cpu_rd_q;
    assign dma_rd    = dma_rd_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4); lock steps run when MEM_PORT_ARBITER_LOCK_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, mem_rd;
    logic [31:0] cpu_rd, dma_rd, mem_addr, mem_wd;
    logic        cpu_ready, dma_ready, mem_en, mem_we, owner, busy;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic        dma_lock;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
`ifdef MEM_PORT_ARBITER_LOCK_EN
        .dma_lock(dma_lock),
`endif
        .dma_rd(dma_rd), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .owner(owner), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wd = 0;
        mem_rd = 32'h0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
        dma_lock = 0;
`endif
        tick(); tick();
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd0);
        check("rst_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
        check("rst_cpu_rd", cpu_rd, 32'd0);
        check("rst_dma_rd", dma_rd, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Single CPU read
        cpu_req = 1; cpu_addr = 32'h40; mem_rd = 32'hDEADBEEF;
        tick();
        check("rd_c1_en", {31'd0, mem_en}, 32'd1);
        check("rd_c1_addr", mem_addr, 32'h40);
        check("rd_c1_we", {31'd0, mem_we}, 32'd0);
        check("rd_c1_busy", {31'd0, busy}, 32'd1);
        check("rd_c1_dma_ready", {31'd0, dma_ready}, 32'd0);
        tick();
        check("rd_c2_en", {31'd0, mem_en}, 32'd1);
        check("rd_c2_ready", {31'd0, cpu_ready}, 32'd0);
        tick();
        check("rd_c3_ready", {31'd0, cpu_ready}, 32'd1);
        check("rd_c3_dma_ready", {31'd0, dma_ready}, 32'd0);
        check("rd_c3_en", {31'd0, mem_en}, 32'd0);
        check("rd_c3_data", cpu_rd, 32'hDEADBEEF);
        cpu_req = 0;
        tick();
        check("rd_c4_ready", {31'd0, cpu_ready}, 32'd0);
        check("rd_c4_busy", {31'd0, busy}, 32'd0);

        // DMA write
        dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wd = 32'h12345678;
        tick();
        check("wr_c1_owner", {31'd0, owner}, 32'd1);
        check("wr_c1_we", {31'd0, mem_we}, 32'd1);
        check("wr_c1_addr", mem_addr, 32'h100);
        check("wr_c1_wd", mem_wd, 32'h12345678);
        dma_addr = 32'hFFFF_0000; dma_wd = 32'h0;
        tick();
        check("wr_c2_we", {31'd0, mem_we}, 32'd1);
        check("wr_c2_addr_latched", mem_addr, 32'h100);
        check("wr_c2_wd_latched", mem_wd, 32'h12345678);
        tick();
        check("wr_c3_ready", {30'd0, cpu_ready, dma_ready}, 32'd1);
        check("wr_c3_dma_rd", dma_rd, 32'd0);
        check("wr_c3_cpu_rd", cpu_rd, 32'hDEADBEEF);
        check("wr_c3_we", {31'd0, mem_we}, 32'd0);
        dma_req = 0; dma_we = 0;
        tick();

        // Simultaneous requests: CPU first, DMA right after
        cpu_req = 1; cpu_addr = 32'h200; dma_req = 1; dma_addr = 32'h300;
        mem_rd = 32'hA5A50001;
        tick();
        check("sim_c1_owner", {31'd0, owner}, 32'd0);
        check("sim_c1_addr", mem_addr, 32'h200);
        tick(); tick();
        check("sim_c3_ready", {30'd0, cpu_ready, dma_ready}, 32'd2);
        check("sim_c3_cpu_rd", cpu_rd, 32'hA5A50001);
        cpu_req = 0; mem_rd = 32'h5A5A0002;
        tick();
        check("sim_c4_busy", {31'd0, busy}, 32'd0);
        tick();
        check("sim_c5_owner", {31'd0, owner}, 32'd1);
        check("sim_c5_addr", mem_addr, 32'h300);
        tick(); tick();
        check("sim_c7_ready", {30'd0, cpu_ready, dma_ready}, 32'd1);
        check("sim_c7_dma_rd", dma_rd, 32'h5A5A0002);
        check("sim_c7_cpu_rd", cpu_rd, 32'hA5A50001);
        dma_req = 0;
        tick();

        // Starvation: four CPU grants, then DMA, then CPU again
        cpu_req = 1; cpu_addr = 32'h400; dma_req = 1; dma_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stv_cpu%0d_owner", k), {31'd0, owner}, 32'd0);
            check($sformatf("stv_cpu%0d_addr", k), mem_addr, 32'h400);
            tick(); tick();
            check($sformatf("stv_cpu%0d_ready", k), {30'd0, cpu_ready, dma_ready}, 32'd2);
            tick();
        end
        tick();
        check("stv_dma_owner", {31'd0, owner}, 32'd1);
        check("stv_dma_addr", mem_addr, 32'h500);
        tick(); tick();
        check("stv_dma_ready", {30'd0, cpu_ready, dma_ready}, 32'd1);
        dma_req = 0;
        tick();
        tick();
        check("stv_regain_owner", {31'd0, owner}, 32'd0);
        tick(); tick();
        check("stv_regain_ready", {30'd0, cpu_ready, dma_ready}, 32'd2);
        cpu_req = 0;
        tick();

        // Reset in the first ACCESS cycle of a CPU read
        cpu_req = 1; cpu_addr = 32'h600; mem_rd = 32'h11112222;
        tick();
        check("rma_c1_en", {31'd0, mem_en}, 32'd1);
        reset = 1;
        tick();
        check("rma_en", {31'd0, mem_en}, 32'd0);
        check("rma_busy", {31'd0, busy}, 32'd0);
        check("rma_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
        check("rma_cpu_rd", cpu_rd, 32'd0);
        reset = 0; cpu_req = 0;
        tick();
        check("rma_no_ready", {30'd0, cpu_ready, dma_ready}, 32'd0);
        cpu_req = 1; cpu_addr = 32'h700; mem_rd = 32'h0BADF00D;
        tick();
        check("rma_new_addr", mem_addr, 32'h700);
        tick(); tick();
        check("rma_new_ready", {30'd0, cpu_ready, dma_ready}, 32'd2);
        check("rma_new_data", cpu_rd, 32'h0BADF00D);
        cpu_req = 0;
        tick();

`ifdef MEM_PORT_ARBITER_LOCK_EN
        // Locked DMA burst holds off the CPU until dma_lock drops
        dma_req = 1; dma_lock = 1; dma_addr = 32'h800; cpu_addr = 32'h900;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lck_dma%0d_owner", k), {31'd0, owner}, 32'd1);
            if (k == 0) cpu_req = 1;
            tick(); tick();
            check($sformatf("lck_dma%0d_ready", k), {30'd0, cpu_ready, dma_ready}, 32'd1);
            if (k == 2) dma_lock = 0;
            tick();
        end
        tick();
        check("lck_cpu_owner", {31'd0, owner}, 32'd0);
        check("lck_cpu_addr", mem_addr, 32'h900);
        tick(); tick();
        check("lck_cpu_ready", {30'd0, cpu_ready, dma_ready}, 32'd2);
        cpu_req = 0; dma_req = 0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
